// File: rtl/bht_pkg.sv
// Shared types, counter encodings and the 2-bit saturating update used by the
// BHT write-port sequencer.
package bht_pkg;

  localparam int BHT_INDEX_W = 5;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [1:0] sat_update(input logic [1:0] old, input logic taken);
    if (taken) return (old == ST)  ? ST  : old + 2'b01;
    else       return (old == SNT) ? SNT : old - 2'b01;
  endfunction

endpackage

// File: rtl/bht_update_ctrl_if.sv
// Lane-update and BHT-port signal bundle. The master side is the execute lanes
// plus BHT storage; the slave side is the update controller.
interface bht_update_ctrl_if #(
  parameter int PC_W    = 11,
  parameter int INDEX_W = 5
);
  logic               branch1;
  logic               branch_taken1;
  logic [PC_W-1:0]    pcE1;
  logic               branch2;
  logic               branch_taken2;
  logic [PC_W-1:0]    pcE2;
  logic               flush_req;
  logic               upd_ready;
  logic               init_done;
  logic [INDEX_W-1:0] bht_rd_index;
  logic [1:0]         bht_rd_data;
  logic               bht_wr_en;
  logic [INDEX_W-1:0] bht_wr_index;
  logic [1:0]         bht_wr_data;

  modport master (
    output branch1, branch_taken1, pcE1,
    output branch2, branch_taken2, pcE2,
    output flush_req, bht_rd_data,
    input  upd_ready, init_done, bht_rd_index,
    input  bht_wr_en, bht_wr_index, bht_wr_data
  );

  modport slave (
    input  branch1, branch_taken1, pcE1,
    input  branch2, branch_taken2, pcE2,
    input  flush_req, bht_rd_data,
    output upd_ready, init_done, bht_rd_index,
    output bht_wr_en, bht_wr_index, bht_wr_data
  );
endinterface

// File: rtl/bht_upd_fifo.sv
// Dual-push / single-pop update queue. Push1 lands ahead of push2 when both
// fire; o_count_nxt lets the owner register a ready flag without extra lag.
module bht_upd_fifo #(
  parameter  int INDEX_W = 5,
  parameter  int DEPTH   = 4,
  localparam int ENT_W   = INDEX_W + 1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push1,
  input  logic [ENT_W-1:0] i_data1,
  input  logic             i_push2,
  input  logic [ENT_W-1:0] i_data2,
  input  logic             i_pop,
  output logic [ENT_W-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_nxt
);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr2;
  logic [PTR_W-1:0] w_wr_ptr_nxt;

  assign w_wr_ptr2    = r_wr_ptr + PTR_W'(i_push1);
  assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(i_push1) + PTR_W'(i_push2);
  assign o_count_nxt  = i_clr ? '0
                      : r_count + CNT_W'(i_push1) + CNT_W'(i_push2) - CNT_W'(i_pop);
  assign o_head       = r_mem[r_rd_ptr];
  assign o_count      = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_count  <= o_count_nxt;
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (!i_clr) begin
      if (i_push1) r_mem[r_wr_ptr]  <= i_data1;
      if (i_push2) r_mem[w_wr_ptr2] <= i_data2;
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT write-port sequencer: post-reset/flush table sweep, then queued
// read-modify-write updates with write-to-read forwarding.
// Optional statistics counters: define BHT_UPD_STATS_EN.
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int PC_W    = 11,
  parameter int INDEX_W = BHT_INDEX_W,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  bht_update_ctrl_if.slave   bus
`ifdef BHT_UPD_STATS_EN
  ,
  output logic [15:0]        stat_updates,
  output logic [15:0]        stat_drops
`endif
);

  // state | meaning
  // INIT  | writing WNT to entries 0..2^INDEX_W-1, one per cycle; lanes not accepted
  // RUN   | accepting lane updates and draining the queue one per cycle

  localparam int ENT_W = INDEX_W + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [INDEX_W:0] SWEEP_END = {1'b1, {INDEX_W{1'b0}}};
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  state_t             r_state;
  logic [INDEX_W:0]   r_sweep_idx;
  logic               r_wr_en;
  logic [INDEX_W-1:0] r_wr_index;
  logic [1:0]         r_wr_data;
  logic               r_upd_ready;

  state_t             w_state_nxt;
  logic [INDEX_W:0]   w_sweep_nxt;
  logic               w_wr_en_nxt;
  logic [INDEX_W-1:0] w_wr_index_nxt;
  logic [1:0]         w_wr_data_nxt;
  logic               w_push1;
  logic               w_push2;
  logic               w_pop;
  logic               w_clr;
  logic [ENT_W-1:0]   w_head;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [1:0]         w_old;
  logic               w_unused_pc;

  assign w_unused_pc = ^{bus.pcE1[PC_W-1:INDEX_W], bus.pcE2[PC_W-1:INDEX_W]};

  bht_upd_fifo #(
    .INDEX_W (INDEX_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_clr       (w_clr),
    .i_push1     (w_push1),
    .i_data1     ({bus.pcE1[INDEX_W-1:0], bus.branch_taken1}),
    .i_push2     (w_push2),
    .i_data2     ({bus.pcE2[INDEX_W-1:0], bus.branch_taken2}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt)
  );

  // The previous strobe has not reached the BHT yet, so a same-index head must
  // see the in-flight value instead of the stale read port.
  assign w_old = (r_wr_en && (r_wr_index == w_head[ENT_W-1:1])) ? r_wr_data
                                                                : bus.bht_rd_data;

  always_comb begin
    w_state_nxt    = r_state;
    w_sweep_nxt    = r_sweep_idx;
    w_wr_en_nxt    = 1'b0;
    w_wr_index_nxt = r_wr_index;
    w_wr_data_nxt  = r_wr_data;
    w_push1        = 1'b0;
    w_push2        = 1'b0;
    w_pop          = 1'b0;
    w_clr          = 1'b0;
    if (bus.flush_req) begin
      w_clr       = 1'b1;
      w_state_nxt = INIT;
      w_sweep_nxt = '0;
    end else begin
      unique case (r_state)
        INIT: begin
          if (r_sweep_idx == SWEEP_END) begin
            w_state_nxt = RUN;
          end else begin
            w_wr_en_nxt    = 1'b1;
            w_wr_index_nxt = r_sweep_idx[INDEX_W-1:0];
            w_wr_data_nxt  = WNT;
            w_sweep_nxt    = r_sweep_idx + 1'b1;
          end
        end
        RUN: begin
          w_push1 = r_upd_ready && bus.branch1;
          w_push2 = r_upd_ready && bus.branch2;
          w_pop   = (w_count != '0);
          if (w_pop) begin
            w_wr_en_nxt    = 1'b1;
            w_wr_index_nxt = w_head[ENT_W-1:1];
            w_wr_data_nxt  = sat_update(w_old, w_head[0]);
          end
        end
        default: w_state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= INIT;
      r_sweep_idx <= '0;
      r_wr_en     <= 1'b0;
      r_wr_index  <= '0;
      r_wr_data   <= WNT;
      r_upd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_index  <= w_wr_index_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_upd_ready <= (w_state_nxt == RUN) && (w_count_nxt <= READY_MAX);
    end
  end

  assign bus.upd_ready    = r_upd_ready;
  assign bus.init_done    = (r_state == RUN);
  assign bus.bht_rd_index = w_head[ENT_W-1:1];
  assign bus.bht_wr_en    = r_wr_en;
  assign bus.bht_wr_index = r_wr_index;
  assign bus.bht_wr_data  = r_wr_data;

`ifdef BHT_UPD_STATS_EN
  logic [15:0] r_stat_updates;
  logic [15:0] r_stat_drops;
  logic [1:0]  w_drop_n;
  logic [16:0] w_drop_sum;
  logic        w_drop_evt;

  assign w_drop_n   = {1'b0, bus.branch1} + {1'b0, bus.branch2};
  assign w_drop_evt = (r_state == RUN) && (!r_upd_ready || bus.flush_req);
  assign w_drop_sum = {1'b0, r_stat_drops} + 17'(w_drop_n);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_updates <= '0;
      r_stat_drops   <= '0;
    end else begin
      if (w_pop && (r_stat_updates != 16'hFFFF))
        r_stat_updates <= r_stat_updates + 16'd1;
      if (w_drop_evt)
        r_stat_drops <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign stat_updates = r_stat_updates;
  assign stat_drops   = r_stat_drops;
`endif

endmodule
